// File: rtl/nids_pkg.sv
// Shared constants and types for the NIDS front-end blocks.
//   ETHERTYPE_IPV4 / IPV4_VER_IHL / IPV4_TOS : byte pattern that marks an IPv4 header
//   HDR_LEN_DEFAULT / ACK_TIMEOUT_DEFAULT    : default header length and ack timeout
//   state_t                                  : header-extractor FSM states
//   restart_state()                          : where the search resumes after a mismatch
package nids_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4      = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL        = 8'h45;
  localparam logic [7:0]  IPV4_TOS            = 8'h00;
  localparam int          HDR_LEN_DEFAULT     = 20;
  localparam int          ACK_TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    S_ETH0,
    S_ETH1,
    S_VER,
    S_TOS,
    S_SEND,
    S_WAIT
  } state_t;

  // A mismatching byte may itself be the start of a new pattern, so it is
  // re-tested against the first ethertype byte in the same cycle.
  function automatic state_t restart_state(input logic [7:0] b);
    return (b == ETHERTYPE_IPV4[15:8]) ? S_ETH1 : S_ETH0;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at 0xFFFF.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears count
//   en    : count one event this cycle
//   count : current value
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/ipv4_hdr_extract.sv
// Scans a raw capture byte stream for 08 00 45 00 (IPv4 ethertype, version/IHL,
// TOS) and forwards the IPv4 header (HDR_LEN bytes, starting with 45 00) to the
// NIDS core one byte at a time using an rx_init strobe / rx_ok acknowledge.
//   clk, rst         : clock and asynchronous active-low reset
//   in_valid/in_data : capture stream byte, accepted when in_valid && in_ready
//   in_ready         : extractor can take a stream byte this cycle
//   rx_init/data_in  : one-cycle strobe and header byte towards the core
//   rx_ok            : core acknowledge, sampled only while waiting
//   hdr_count        : headers fully forwarded (saturating)
//   abort_count      : headers aborted by ack timeout (saturating), only when
//                      the IPV4_STATS_EN macro is defined
module ipv4_hdr_extract
  import nids_pkg::*;
#(
  parameter int HDR_LEN     = HDR_LEN_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        rx_init,
  output logic [7:0]  data_in,
  input  logic        rx_ok,
  output logic [15:0] hdr_count
`ifdef IPV4_STATS_EN
  ,
  output logic [15:0] abort_count
`endif
);

  localparam int IW = $clog2(HDR_LEN);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_IDX         = IW'(HDR_LEN - 1);
  localparam logic [IW-1:0] FIRST_STREAM_IDX = IW'(2);
  localparam logic [WW-1:0] WAIT_LAST        = WW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    ETH1_BYTE        = ETHERTYPE_IPV4[7:0];

  state_t        state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wait_cnt;

  logic accept;
  logic ack;
  logic timeout;
  logic hdr_done;

  assign accept = in_valid && in_ready;
  // While rx_init is high the core has not seen the byte yet, so an rx_ok in
  // that cycle belongs to nothing and is ignored.
  assign ack      = (state == S_WAIT) && !rx_init && rx_ok;
  assign timeout  = (state == S_WAIT) && !rx_init && !rx_ok && (wait_cnt == WAIT_LAST);
  assign hdr_done = ack && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_ETH0;
      idx      <= '0;
      wait_cnt <= '0;
      rx_init  <= 1'b0;
      data_in  <= '0;
      in_ready <= 1'b0;
    end else begin
      // NOTE: every register here is assigned with <= so all branches read the
      // pre-edge values; later assignments in the same pass override the defaults.
      rx_init <= 1'b0;
      unique case (state)
        S_ETH0: begin
          in_ready <= 1'b1;
          if (accept) state <= restart_state(in_data);
        end
        S_ETH1: begin
          in_ready <= 1'b1;
          if (accept) state <= (in_data == ETH1_BYTE) ? S_VER : restart_state(in_data);
        end
        S_VER: begin
          in_ready <= 1'b1;
          if (accept) state <= (in_data == IPV4_VER_IHL) ? S_TOS : restart_state(in_data);
        end
        S_TOS: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (in_data == IPV4_TOS) begin
              state    <= S_SEND;
              idx      <= '0;
              in_ready <= 1'b0;
            end else begin
              state <= restart_state(in_data);
            end
          end
        end
        S_SEND: begin
          // The two pattern bytes already consumed are replayed from constants;
          // only then does the stream feed the remaining header bytes.
          if (idx < FIRST_STREAM_IDX) begin
            rx_init  <= 1'b1;
            data_in  <= (idx == '0) ? IPV4_VER_IHL : IPV4_TOS;
            state    <= S_WAIT;
            wait_cnt <= '0;
            in_ready <= 1'b0;
          end else if (accept) begin
            rx_init  <= 1'b1;
            data_in  <= in_data;
            state    <= S_WAIT;
            wait_cnt <= '0;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ack) begin
            if (hdr_done) begin
              state    <= S_ETH0;
              idx      <= '0;
              in_ready <= 1'b1;
            end else begin
              state    <= S_SEND;
              idx      <= idx + 1'b1;
              // Next index >= 2 means the next byte comes from the stream.
              in_ready <= (idx != '0);
            end
          end else if (timeout) begin
            state    <= S_ETH0;
            idx      <= '0;
            in_ready <= 1'b1;
          end else if (!rx_init) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_ETH0;
          idx      <= '0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  sat_counter16 u_hdr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hdr_done),
    .count (hdr_count)
  );

`ifdef IPV4_STATS_EN
  sat_counter16 u_abort_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (timeout),
    .count (abort_count)
  );
`endif

endmodule

// File: tb/tb_ipv4_hdr_extract.sv
// Self-checking bench for ipv4_hdr_extract: table of stream vectors with
// hand-derived expectations plus hand-written timeout and mid-header reset
// sequences. Build with IPV4_STATS_EN defined to also check abort_count.
module tb_ipv4_hdr_extract;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rx_init;
  logic [7:0]  data_in;
  logic        rx_ok;
  logic [15:0] hdr_count;
`ifdef IPV4_STATS_EN
  logic [15:0] abort_count;
  int          exp_abort;
`endif

  ipv4_hdr_extract dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rx_init   (rx_init),
    .data_in   (data_in),
    .rx_ok     (rx_ok),
    .hdr_count (hdr_count)
`ifdef IPV4_STATS_EN
    ,
    .abort_count (abort_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- core-side responder and strobe monitor ----------------
  logic [7:0] strobe_q[$];
  int         strobe_cyc[$];
  int         width_err, ready_err, acks_given, ack_max, ack_mode, ack_delay, wcnt;
  bit         waiting, prev_init, chk_ready;

  initial begin
    rx_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_init) begin
        if (prev_init) width_err++;
        strobe_q.push_back(data_in);
        strobe_cyc.push_back(cyc);
        if (chk_ready && in_ready) ready_err++;
        waiting = 1'b1;
        wcnt = 0;
      end else if (waiting) begin
        if (chk_ready && in_ready) ready_err++;
        wcnt++;
      end
      prev_init = rx_init;
      if (ack_mode == 1) rx_ok = 1'b1;
      else rx_ok = waiting && !rx_init && (wcnt >= ack_delay) && (acks_given < ack_max);
      if (rx_ok && waiting && !rx_init) begin
        waiting = 1'b0;
        acks_given++;
      end
    end
  end

  task automatic clear_mon();
    strobe_q.delete();
    strobe_cyc.delete();
    width_err  = 0;
    ready_err  = 0;
    acks_given = 0;
    waiting    = 1'b0;
    prev_init  = 1'b0;
  endtask

  // ---------------- stream driver ----------------
  logic [7:0] stim[$];
  int         tos_idx, tos_cyc;

  task automatic drive(input bit rnd);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < stim.size() && guard < 3000) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = stim[i];
      if (in_valid && in_ready) begin
        if (i == tos_idx) tos_cyc = cyc;
        i++;
      end
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("drive_all_bytes_accepted", i, stim.size());
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (strobe_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_strobes", strobe_q.size(), n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [47:0] prefix;     // right-aligned, first byte most significant
    int          plen;
    int          ack_mode;   // 0: ack ack_delay cycles after strobe, 1: rx_ok held high
    int          ack_delay;
    bit          rnd;        // randomise in_valid
    int          exp_strobes;
    int          exp_inc;
  } vec_t;

  vec_t vecs[8];
  int   exp_hdr;

  task automatic set_vec(input int i, input string nm, input logic [47:0] p, input int pl,
                         input int am, input int ad, input bit r, input int es, input int ei);
    vecs[i].name        = nm;
    vecs[i].prefix      = p;
    vecs[i].plen        = pl;
    vecs[i].ack_mode    = am;
    vecs[i].ack_delay   = ad;
    vecs[i].rnd         = r;
    vecs[i].exp_strobes = es;
    vecs[i].exp_inc     = ei;
  endtask

  task automatic load_stim(input logic [47:0] p, input int plen);
    stim.delete();
    for (int k = 0; k < plen; k++) stim.push_back(p[8*(plen-1-k) +: 8]);
    for (int k = 1; k <= 18; k++) stim.push_back(8'(k));
    tos_idx = plen - 1;
    tos_cyc = -100;
  endtask

  task automatic run_vec(input int v);
    int bad, lat, min_gap, max_gap, g;
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    clear_mon();
    ack_mode  = vecs[v].ack_mode;
    ack_delay = vecs[v].ack_delay;
    ack_max   = 1000;
    chk_ready = 1'b1;
    load_stim(vecs[v].prefix, vecs[v].plen);
    drive(vecs[v].rnd);
    repeat (40) @(negedge clk);
    exp_hdr += vecs[v].exp_inc;
    check({vecs[v].name, "_strobes"}, strobe_q.size(), vecs[v].exp_strobes);
    check({vecs[v].name, "_hdr_count"}, int'(hdr_count), exp_hdr);
    check({vecs[v].name, "_strobe_width"}, width_err, 0);
    check({vecs[v].name, "_in_ready_while_wait"}, ready_err, 0);
    if (vecs[v].exp_strobes > 0) begin
      bad = 0;
      for (int k = 0; k < strobe_q.size(); k++) begin
        exp_b = (k == 0) ? 8'h45 : (k == 1) ? 8'h00 : 8'(k - 1);
        if (strobe_q[k] != exp_b) bad++;
      end
      check({vecs[v].name, "_byte_errors"}, bad, 0);
      lat = (strobe_cyc.size() > 0) ? strobe_cyc[0] - tos_cyc : -1;
      check({vecs[v].name, "_first_strobe_latency"}, lat, 2);
      min_gap = 1000000;
      max_gap = 0;
      for (int k = 1; k < strobe_cyc.size(); k++) begin
        g = strobe_cyc[k] - strobe_cyc[k-1];
        if (g < min_gap) min_gap = g;
        if (g > max_gap) max_gap = g;
      end
      check_range({vecs[v].name, "_min_gap"}, min_gap, 3, 100000);
      if (vecs[v].ack_mode == 1 && !vecs[v].rnd)
        check({vecs[v].name, "_max_gap"}, max_gap, 3);
    end
  endtask

  // ---------------- main sequence ----------------
  int t5, n_wait;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ack_mode  = 0;
    ack_delay = 1;
    ack_max   = 1000;
    chk_ready = 1'b0;
    exp_hdr   = 0;
`ifdef IPV4_STATS_EN
    exp_abort = 0;
`endif
    clear_mon();

    set_vec(0, "basic",        48'h08004500,     4, 0, 1, 1'b0, 20, 1);
    set_vec(1, "double_08",    48'h0808004500,   5, 0, 1, 1'b0, 20, 1);
    set_vec(2, "bad_ver",      48'h08004600,     4, 0, 1, 1'b0,  0, 0);
    set_vec(3, "bad_tos",      48'h0800454500,   5, 0, 1, 1'b0,  0, 0);
    set_vec(4, "ver_restart",  48'h080008004500, 6, 0, 1, 1'b0, 20, 1);
    set_vec(5, "rx_ok_held",   48'h08004500,     4, 1, 1, 1'b0, 20, 1);
    set_vec(6, "slow_ack",     48'h08004500,     4, 0, 4, 1'b0, 20, 1);
    set_vec(7, "random_valid", 48'h08004500,     4, 0, 1, 1'b1, 20, 1);

    // Reset values and in_ready rising on the first edge after release.
    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_rx_init", int'(rx_init), 0);
    check("reset_data_in", int'(data_in), 0);
    check("reset_hdr_count", int'(hdr_count), 0);
`ifdef IPV4_STATS_EN
    check("reset_abort_count", int'(abort_count), 0);
`endif
    rst = 1'b1;
    #1;
    check("in_ready_before_first_edge", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_after_first_edge", int'(in_ready), 1);

    for (int v = 0; v < 8; v++) run_vec(v);

    // Ack timeout: only four strobes get an rx_ok, the fifth is left hanging.
    @(posedge clk);
    #1;
    clear_mon();
    chk_ready = 1'b0;
    ack_mode  = 0;
    ack_delay = 1;
    ack_max   = 4;
    stim.delete();
    stim.push_back(8'h08); stim.push_back(8'h00); stim.push_back(8'h45); stim.push_back(8'h00);
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03);
    tos_idx = 3;
    drive(1'b0);
    wait_strobes(5, 100);
    t5 = (strobe_cyc.size() >= 5) ? strobe_cyc[4] : cyc;
    n_wait = 0;
    while (!in_ready && n_wait < 400) begin
      @(negedge clk);
      n_wait++;
    end
    check_range("abort_latency", cyc - t5, 255, 257);
    repeat (20) @(negedge clk);
    check("abort_strobes", strobe_q.size(), 5);
    check("abort_hdr_count", int'(hdr_count), exp_hdr);
`ifdef IPV4_STATS_EN
    exp_abort++;
    check("abort_count", int'(abort_count), exp_abort);
`endif
    run_vec(0);

    // Reset pulsed while the tenth strobe waits for its acknowledge.
    @(posedge clk);
    #1;
    clear_mon();
    chk_ready = 1'b0;
    ack_mode  = 0;
    ack_delay = 5;
    ack_max   = 1000;
    load_stim(48'h08004500, 4);
    fork
      drive(1'b0);
      begin
        wait_strobes(10, 500);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_hdr = 0;
        check("midrst_rx_init", int'(rx_init), 0);
        check("midrst_data_in", int'(data_in), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_hdr_count", int'(hdr_count), exp_hdr);
`ifdef IPV4_STATS_EN
        exp_abort = 0;
        check("midrst_abort_count", int'(abort_count), exp_abort);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    check("midrst_no_more_strobes", strobe_q.size(), 10);
    check("midrst_hdr_count_after", int'(hdr_count), exp_hdr);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ipv4_hdr_extract.md
IPV4_HDR_EXTRACT -- requirements
Module: ipv4_hdr_extract

Interface
REQ-001 Parameter: HDR_LEN, 20, IPv4 header bytes forwarded per match, including the two pattern bytes.
REQ-002 Parameter: ACK_TIMEOUT, 255, cycles to wait for rx_ok before aborting a header.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  sole clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  1  in_data holds a raw capture-stream byte.
REQ-007 Port: in_data  input  8  capture-stream byte.
REQ-008 Port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-009 Port: rx_init  output  1  one-cycle strobe; data_in valid to the downstream nids core.
REQ-010 Port: data_in  output  8  header byte to nids.
REQ-011 Port: rx_ok  input  1  nids acknowledge; the byte was consumed.
REQ-012 Port: hdr_count  output  16  headers fully forwarded.
REQ-013 Port: abort_count  output  16  headers aborted by timeout; present only with IPV4_STATS_EN.

Function
REQ-014 FSM states: S_ETH0 (expect 0x08), S_ETH1 (0x00), S_VER (0x45), S_TOS (0x00), S_SEND, S_WAIT.
- Each S_ETH0..S_TOS advances on an accepted byte equal to the expected value.
REQ-015 Mismatch in S_ETH1..S_TOS: return to S_ETH0 and re-evaluate the same byte against 0x08 in that cycle; so 0x08,0x08,0x00,0x45,0x00 matches.
REQ-016 On the S_TOS match: load byte index 0, enter S_SEND, and forward 0x45 then 0x00 from constants before consuming further stream bytes.
REQ-017 S_SEND, byte source: index 0..1 send the constants; index 2..HDR_LEN-1 send the next accepted stream byte.
REQ-018 S_SEND, strobe: drive rx_init=1 for exactly one cycle with data_in stable, then enter S_WAIT.
REQ-019 data_in SHALL hold its value until the next strobe.
REQ-020 in_ready SHALL be 1 in S_ETH0..S_TOS and in S_SEND when index>=2 and no strobe is pending; 0 otherwise.
REQ-021 rx_ok is sampled only in S_WAIT; rx_ok asserted in the same cycle as rx_init is ignored.
REQ-022 S_WAIT, on rx_ok: increment the index.
- index==HDR_LEN: increment hdr_count (saturating) and go to S_ETH0.
- Otherwise: return to S_SEND.
REQ-023 S_WAIT, timeout: ACK_TIMEOUT cycles without rx_ok abort the header, go to S_ETH0 and increment abort_count (saturating); stream bytes after the abort are searched normally.
REQ-024 Latency: first rx_init 1 cycle after the S_TOS match byte is accepted; minimum 3 cycles per forwarded byte (strobe, wait, ack).
REQ-025 Bytes are never dropped or duplicated between acceptance and forwarding.
REQ-026 Counters are 16-bit unsigned and saturate at 0xFFFF.

Reset
REQ-027 While rst=0: state S_ETH0, index 0, rx_init 0, data_in 0x00, in_ready 0, counters 0.
REQ-028 in_ready rises on the first clock edge after rst deasserts.
REQ-029 Reset asserted mid-header discards the partial header; no further strobe is issued and no counter increments.

Configuration
REQ-030 With IPV4_STATS_EN defined: the abort_count port and counter exist.
REQ-031 Without IPV4_STATS_EN: no abort_count port or counter; timeout still aborts the header; hdr_count is always present.

Structure
REQ-032 Package nids_pkg holds: ETHERTYPE_IPV4 = 16'h0800, IPV4_VER_IHL = 8'h45, IPV4_TOS = 8'h00, the FSM state enum, and HDR_LEN_DEFAULT.
REQ-033 Sub-module: one, sat_counter16 (enable, saturate), instantiated for each counter.

Verification
REQ-034 Stream 08 00 45 00 + 18 bytes 01..12, rx_ok 1 cycle after each strobe -> 20 strobes carrying 45 00 01..12; hdr_count=1.
REQ-035 Stream 08 08 00 45 00 + 18 bytes -> header detected; first two strobes 45, 00.
REQ-036 Stream 08 00 46 00 ... -> no strobe; FSM returns to S_ETH0; hdr_count=0.
REQ-037 Header start, rx_ok withheld for 255 cycles after the 5th strobe -> abort, state S_ETH0, abort_count=1 (with IPV4_STATS_EN), hdr_count=0.
REQ-038 rst=0 pulsed during the 10th strobe wait -> all outputs return to reset values; a subsequent full header forwards correctly with hdr_count=1.
REQ-039 in_valid toggled randomly at 50% across a header -> rx_init byte sequence identical to REQ-034; in_ready=0 whenever in S_WAIT.
